// File: rtl/spi_packet_tx.sv
// Write-only SPI (mode 0) packet serialiser for an LCD controller: one {dc, byte}
// packet per handshake, MSB first, with back-to-back streaming under one chip select.
//
//   state | meaning
//   IDLE  | cs_n high, sck low, dc/sda hold last values, ready high
//   SHIFT | serialising the byte, CLK_DIV cycles per SCK half-period
//   HOLD  | CLK_DIV cycles of cs_n low after the last bit; ready on its final cycle
module spi_packet_tx #(
   parameter int WORD_WIDTH   = 8,
   parameter int PACKET_WIDTH = 9,
   parameter int CLK_DIV      = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid,
   output logic                    ready,
   input  logic [PACKET_WIDTH-1:0] data,
   output logic                    lcd_sck,
   output logic                    lcd_sda,
   output logic                    lcd_dc,
   output logic                    lcd_cs_n,
   output logic                    busy
);

   localparam int DIVW = $clog2(CLK_DIV) + 1;
   localparam int BITW = $clog2(WORD_WIDTH);
   localparam logic [DIVW-1:0] DIV_LOAD = DIVW'(CLK_DIV - 1);
   localparam logic [BITW-1:0] BIT_LAST = BITW'(WORD_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                  state_q;
   logic [DIVW-1:0]         div_q;
   logic [BITW-1:0]         bit_q;
   logic [WORD_WIDTH-1:0]   shreg_q;
   logic                    sck_q;
   logic                    sda_q;
   logic                    dc_q;
   logic                    cs_n_q;
   logic                    accept;

   // The divider is a down-counter; terminal count zero ends a half-period or the hold.
   assign ready  = rst && ((state_q == IDLE) || ((state_q == HOLD) && (div_q == '0)));
   assign accept = valid && ready;

   assign busy     = (state_q != IDLE);
   assign lcd_sck  = sck_q;
   assign lcd_sda  = sda_q;
   assign lcd_dc   = dc_q;
   assign lcd_cs_n = cs_n_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sck_q   <= 1'b0;
         sda_q   <= 1'b0;
         dc_q    <= 1'b0;
         cs_n_q  <= 1'b1;
      end else if (accept) begin
         state_q <= SHIFT;
         div_q   <= DIV_LOAD;
         bit_q   <= '0;
         shreg_q <= {data[WORD_WIDTH-2:0], 1'b0};
         sda_q   <= data[WORD_WIDTH-1];
         dc_q    <= data[PACKET_WIDTH-1];
         sck_q   <= 1'b0;
         cs_n_q  <= 1'b0;
      end else begin
         case (state_q)
            SHIFT: begin
               if (div_q != '0) begin
                  div_q <= div_q - DIVW'(1);
               end else begin
                  div_q <= DIV_LOAD;
                  sck_q <= ~sck_q;
                  // Falling SCK: advance to the next bit, or finish after the last one.
                  if (sck_q) begin
                     if (bit_q == BIT_LAST) begin
                        state_q <= HOLD;
                        bit_q   <= '0;
                     end else begin
                        bit_q   <= bit_q + BITW'(1);
                        sda_q   <= shreg_q[WORD_WIDTH-1];
                        shreg_q <= shreg_q << 1;
                     end
                  end
               end
            end
            HOLD: begin
               if (div_q != '0) begin
                  div_q <= div_q - DIVW'(1);
               end else begin
                  state_q <= IDLE;
                  cs_n_q  <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_packet_tx.sv
// Bench for spi_packet_tx: cycle-accurate reference model computed from transfer
// timing arithmetic, a table of single packets, streaming/abort/gap sequences, random traffic.
module tb_spi_packet_tx;

   localparam int CD     = 2;
   localparam int XFER   = 17 * CD;
   localparam int SHIFTC = 16 * CD;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       valid = 1'b0;
   logic [8:0] data  = '0;
   logic       ready, lcd_sck, lcd_sda, lcd_dc, lcd_cs_n, busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bit         m_active = 1'b0;
   int         m_k      = 0;
   logic [8:0] m_pkt    = '0;
   logic       m_sda    = 1'b0;
   logic       m_dc     = 1'b0;

   int         sck_rises     = 0;
   logic [7:0] cap           = '0;
   logic       prev_sck      = 1'b0;
   logic       prev_dc       = 1'b0;
   int         dc_change_cyc = -1;
   int         acc_q[$];
   logic [8:0] spk[3];

   typedef struct {
      logic [8:0] pkt;
      logic [7:0] exp_byte;
      logic       exp_dc;
      int         exp_cs_low;
   } vec_t;
   vec_t vecs[4];

   spi_packet_tx #(.WORD_WIDTH(8), .PACKET_WIDTH(9), .CLK_DIV(CD)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid    (valid),
      .ready    (ready),
      .data     (data),
      .lcd_sck  (lcd_sck),
      .lcd_sda  (lcd_sda),
      .lcd_dc   (lcd_dc),
      .lcd_cs_n (lcd_cs_n),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected {ready, busy, cs_n, sck, sda, dc} for the current cycle.
   function automatic logic [5:0] model_out(input logic r);
      logic sck, sda, rdy;
      if (m_active) begin
         if (m_k < SHIFTC) begin
            sck = (m_k % (2 * CD)) >= CD;
            sda = m_pkt[7 - m_k / (2 * CD)];
         end else begin
            sck = 1'b0;
            sda = m_pkt[0];
         end
         rdy = r && (m_k == XFER - 1);
         return {rdy, 1'b1, 1'b0, sck, sda, m_pkt[8]};
      end
      return {r, 1'b0, 1'b1, 1'b0, m_sda, m_dc};
   endfunction

   task automatic step(input logic r, input logic v, input logic [8:0] d);
      logic [5:0] exp;
      rst = r; valid = v; data = d;
      #1;
      exp = model_out(r);
      check("outputs{rdy,busy,cs_n,sck,sda,dc}",
            32'({ready, busy, lcd_cs_n, lcd_sck, lcd_sda, lcd_dc}), 32'(exp));
      if (lcd_sck && !prev_sck) begin
         sck_rises++;
         cap = {cap[6:0], lcd_sda};
      end
      prev_sck = lcd_sck;
      if (lcd_dc !== prev_dc) dc_change_cyc = cyc;
      prev_dc = lcd_dc;
      if (r && v && ready) acc_q.push_back(cyc);
      @(posedge clk);
      if (!r) begin
         m_active = 1'b0; m_sda = 1'b0; m_dc = 1'b0;
      end else if (v && exp[5]) begin
         m_active = 1'b1; m_k = 0; m_pkt = d; m_dc = d[8];
      end else if (m_active) begin
         m_k++;
         if (m_k == XFER) begin
            m_active = 1'b0;
            m_sda    = m_pkt[0];
         end
      end
      cyc++;
      #1;
   endtask

   task automatic send_single(input logic [8:0] d, input logic [7:0] eb, input logic edc,
                              input int ecs);
      int cnt = 0;
      sck_rises = 0;
      step(1'b1, 1'b1, d);
      while (lcd_cs_n == 1'b0 && cnt < 100) begin
         step(1'b1, 1'b0, 9'h0);
         cnt++;
      end
      check("single cs_n low cycles", cnt, ecs);
      check("single sda bits", 32'(cap), 32'(eb));
      check("single sck rises", sck_rises, 8);
      check("single dc", 32'(lcd_dc), 32'(edc));
      step(1'b1, 1'b0, 9'h0);
   endtask

   // Streams spk[0..n-1] with valid held high; returns accept gaps and cs_n breaks.
   task automatic run_stream(input int n, output int gap1, output int gap2, output int brk);
      int idx = 0;
      int cnt = 0;
      int sz;
      acc_q.delete();
      sck_rises = 0;
      brk = 0;
      while (idx < n && cnt < 200) begin
         sz = acc_q.size();
         step(1'b1, 1'b1, spk[idx]);
         if (acc_q.size() > sz) idx++;
         if (idx > 0 && lcd_cs_n) brk++;
         cnt++;
      end
      while (lcd_cs_n == 1'b0 && cnt < 400) begin
         step(1'b1, 1'b0, 9'h0);
         cnt++;
      end
      gap1 = (acc_q.size() >= 2) ? acc_q[1] - acc_q[0] : -1;
      gap2 = (acc_q.size() >= 3) ? acc_q[2] - acc_q[1] : -1;
      step(1'b1, 1'b0, 9'h0);
   endtask

   initial begin
      int g1, g2, brk, cnt, cs_high;
      vecs[0] = '{9'h02C, 8'h2C, 1'b0, 34};
      vecs[1] = '{9'h1FC, 8'hFC, 1'b1, 34};
      vecs[2] = '{9'h155, 8'h55, 1'b1, 34};
      vecs[3] = '{9'h081, 8'h81, 1'b0, 34};

      repeat (2) @(posedge clk);
      #1;

      // Reset held with valid asserted.
      repeat (3) step(1'b0, 1'b1, 9'h1FF);
      check("reset cs_n", 32'(lcd_cs_n), 1);
      check("reset sck", 32'(lcd_sck), 0);
      check("reset busy", 32'(busy), 0);
      step(1'b1, 1'b0, 9'h0);

      for (int i = 0; i < 4; i++)
         send_single(vecs[i].pkt, vecs[i].exp_byte, vecs[i].exp_dc, vecs[i].exp_cs_low);

      // Three back-to-back data packets.
      spk[0] = 9'h1FC; spk[1] = 9'h100; spk[2] = 9'h100;
      run_stream(3, g1, g2, brk);
      check("b2b accepts", acc_q.size(), 3);
      check("b2b gap1", g1, XFER);
      check("b2b gap2", g2, XFER);
      check("b2b cs_n breaks", brk, 0);
      check("b2b sck pulses", sck_rises, 24);

      // Command followed by data back-to-back.
      spk[0] = 9'h02C; spk[1] = 9'h1FC; spk[2] = 9'h000;
      dc_change_cyc = -1;
      run_stream(2, g1, g2, brk);
      check("dc switch accepts", acc_q.size(), 2);
      check("dc switch gap", g1, XFER);
      check("dc switch cycle", dc_change_cyc, (acc_q.size() >= 2) ? acc_q[1] + 1 : -2);
      check("dc switch sck pulses", sck_rises, 16);
      check("dc switch last byte", 32'(cap), 32'h0FC);

      // Abort during bit 4, then a clean packet.
      sck_rises = 0;
      cnt = 0;
      step(1'b1, 1'b1, 9'h1AA);
      while (sck_rises < 5 && cnt < 100) begin
         step(1'b1, 1'b0, 9'h0);
         cnt++;
      end
      step(1'b0, 1'b0, 9'h0);
      check("abort cs_n", 32'(lcd_cs_n), 1);
      check("abort busy", 32'(busy), 0);
      check("abort sck", 32'(lcd_sck), 0);
      step(1'b1, 1'b0, 9'h0);
      send_single(9'h155, 8'h55, 1'b1, 34);

      // valid low through HOLD: must return to IDLE before the next packet.
      acc_q.delete();
      step(1'b1, 1'b1, 9'h1A5);
      repeat (XFER) step(1'b1, 1'b0, 9'h0);
      cs_high = 0;
      cnt = 0;
      while (acc_q.size() < 2 && cnt < 50) begin
         if (lcd_cs_n) cs_high++;
         step(1'b1, 1'b1, 9'h0C3);
         cnt++;
      end
      check("gap accepts", acc_q.size(), 2);
      check("gap cs_n high seen", int'(cs_high >= 1), 1);
      cnt = 0;
      while (lcd_cs_n == 1'b0 && cnt < 100) begin
         step(1'b1, 1'b0, 9'h0);
         cnt++;
      end

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, 9'($urandom));
      repeat (XFER + 2) step(1'b1, 1'b0, 9'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
